// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered framebuffer controller:
// geometry, pixel/RGB types, FSM state encoding and the 4-bit palette.
package fb_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int ADDR_W   = 19;
    localparam int COLOR_W  = 4;

    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        WRITE     = 2'd0,
        WAIT_SWAP = 2'd1,
        CLEAR     = 2'd2
    } fb_state_t;

    // Bits 0..2 switch the red/green/blue channels on; bit 3 halves the level.
    function automatic rgb_t palette(input color_t idx);
        rgb_t       rgb;
        logic [3:0] lvl;
        lvl   = idx[3] ? 4'h8 : 4'hF;
        rgb.r = idx[0] ? lvl : 4'h0;
        rgb.g = idx[1] ? lvl : 4'h0;
        rgb.b = idx[2] ? lvl : 4'h0;
        return rgb;
    endfunction

endpackage

// File: rtl/fb_dbuf_controller_bram.sv
// Simple dual-port frame store: one write port, one read port with a
// single-cycle synchronous read. One instance holds one full frame.
module fb_bram
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  color_t            i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output color_t            o_rdata
);

    color_t r_mem [0:FB_DEPTH-1];
    color_t r_rdata;

    // Write the addressed pixel and register the read data on every edge.
    // NOTE: the array has no reset on purpose; a reset loop over every word
    // would stop it mapping onto block RAM, and contents are defined by writers.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fb_dbuf_controller.sv
// Double-buffered 4-bit-per-pixel framebuffer between the pattern writers and
// the VGA pins. Writers fill the back buffer; scan-out reads the front buffer;
// a done pulse swaps the two at the next frame boundary.
// Optional feature: define FB_DBUF_CLEAR_EN to zero the new back buffer after
// every swap and after reset before writes are accepted again.
module fb_dbuf_controller
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] w_addr,
    input  logic        en_w,
    input  logic [3:0]  color_in,
    input  logic        done,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    output logic        ready,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue
);

    localparam logic [8:0]        LAST_ROW  = 9'(V_RES - 1);
    localparam logic [9:0]        LAST_COL  = 10'(H_RES - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(FB_DEPTH);
`ifdef FB_DBUF_CLEAR_EN
    localparam fb_state_t         RST_STATE = CLEAR;
`else
    localparam fb_state_t         RST_STATE = WRITE;
`endif

    fb_state_t         r_state;
    fb_state_t         w_next_state;
    logic              r_ready;
    logic              w_ready_next;
    logic              r_front_sel;
    logic              w_swap;
    logic              w_frame_end;

    logic              w_back_we;
    logic              w_we0;
    logic              w_we1;
    logic [ADDR_W-1:0] w_waddr;
    color_t            w_wdata;

    logic [ADDR_W-1:0] w_scan_addr;
    logic              w_scan_active;
    logic [ADDR_W-1:0] r_scan_addr;
    logic              r_scan_active;
    logic              r_rd_active;
    logic              r_rd_sel;
    color_t            w_rd0;
    color_t            w_rd1;
    color_t            w_pix;
    rgb_t              r_rgb;

`ifdef FB_DBUF_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_clr_last;

    assign w_clr_last = (r_clr_cnt == DEPTH_A - 1'b1);
`endif

    assign w_frame_end   = (row == LAST_ROW) && (col == LAST_COL);
    // Widen before multiplying so the 19-bit product never truncates.
    assign w_scan_addr   = ADDR_W'(row) * ADDR_W'(H_RES) + ADDR_W'(col);
    assign w_scan_active = (row < 9'(V_RES)) && (col < 10'(H_RES));

    // State register, registered ready flag and front-buffer selector.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RST_STATE;
            r_ready     <= 1'b0;
            r_front_sel <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= w_ready_next;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    // Next-state logic: done requests a swap, the frame boundary performs it.
    // NOTE: every combinational output gets a default first so no path is
    // left unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WRITE: begin
                if (done) begin
                    w_next_state = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (w_frame_end) begin
`ifdef FB_DBUF_CLEAR_EN
                    w_next_state = CLEAR;
`else
                    w_next_state = WRITE;
`endif
                end
            end
`ifdef FB_DBUF_CLEAR_EN
            CLEAR: begin
                if (w_clr_last) begin
                    w_next_state = WRITE;
                end
            end
`endif
            default: w_next_state = RST_STATE;
        endcase
    end

    // Outputs of the FSM: ready, swap strobe and the back-buffer write port mux.
    always_comb begin
        w_ready_next = (w_next_state == WRITE);
        w_swap       = (r_state == WAIT_SWAP) && w_frame_end;
        w_back_we    = 1'b0;
        w_waddr      = w_addr;
        w_wdata      = color_in;
        case (r_state)
            WRITE: w_back_we = en_w && (w_addr < DEPTH_A);
`ifdef FB_DBUF_CLEAR_EN
            CLEAR: begin
                w_back_we = 1'b1;
                w_waddr   = r_clr_cnt;
                w_wdata   = '0;
            end
`endif
            default: w_back_we = 1'b0;
        endcase
        // The back buffer is whichever instance is not being scanned out.
        w_we0 = w_back_we &&  r_front_sel;
        w_we1 = w_back_we && !r_front_sel;
    end

`ifdef FB_DBUF_CLEAR_EN
    // Clear address counter: sweeps the whole back buffer once per CLEAR visit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR && !w_clr_last) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end else begin
            r_clr_cnt <= '0;
        end
    end
`endif

    fb_bram u_buf0 (
        .clk     (clk),
        .i_we    (w_we0),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_scan_addr),
        .o_rdata (w_rd0)
    );

    fb_bram u_buf1 (
        .clk     (clk),
        .i_we    (w_we1),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_scan_addr),
        .o_rdata (w_rd1)
    );

    // The selector is captured alongside the read, so a swap applies to reads
    // issued from the cycle after the toggle onwards.
    assign w_pix = r_rd_sel ? w_rd1 : w_rd0;

    // Scan-out pipeline: register address, read front buffer, drive palette RGB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_addr   <= '0;
            r_scan_active <= 1'b0;
            r_rd_active   <= 1'b0;
            r_rd_sel      <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_scan_addr   <= w_scan_addr;
            r_scan_active <= w_scan_active;
            r_rd_active   <= r_scan_active;
            r_rd_sel      <= r_front_sel;
            r_rgb         <= r_rd_active ? palette(w_pix) : '0;
        end
    end

    assign ready    = r_ready;
    assign vgaRed   = r_rgb.r;
    assign vgaGreen = r_rgb.g;
    assign vgaBlue  = r_rgb.b;

endmodule

// File: tb/tb_fb_dbuf_controller.sv
// Scoreboard bench for fb_dbuf_controller: scan requests push the expected RGB,
// a negedge monitor pops and compares when the request leaves the pipeline.
module tb_fb_dbuf_controller;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] w_addr = '0;
    logic        en_w = 1'b0;
    logic [3:0]  color_in = '0;
    logic        done = 1'b0;
    logic [8:0]  row = 9'd500;
    logic [9:0]  col = '0;
    logic        ready;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;
    logic [11:0] rgb_now;

    typedef struct {
        logic [11:0] rgb;
        int          r;
        int          c;
    } exp_t;

    exp_t       exp_q[$];
    logic       tag_now  = 1'b0;
    logic [2:0] tag_pipe = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    fb_dbuf_controller dut (
        .clk      (clk),
        .rst      (rst),
        .w_addr   (w_addr),
        .en_w     (en_w),
        .color_in (color_in),
        .done     (done),
        .row      (row),
        .col      (col),
        .ready    (ready),
        .vgaRed   (vgaRed),
        .vgaGreen (vgaGreen),
        .vgaBlue  (vgaBlue)
    );

    assign rgb_now = {vgaRed, vgaGreen, vgaBlue};

    always #5 clk = ~clk;

    // Scan requests emerge on the pins three edges after they are driven.
    always @(posedge clk) tag_pipe <= {tag_pipe[1:0], tag_now};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (tag_pipe[2]) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: rgb %0h with no expectation queued", rgb_now);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rgb(%0d,%0d)", e.r, e.c), {20'd0, rgb_now}, {20'd0, e.rgb});
            end
        end
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic idle(input int n);
        row = 9'd500;
        col = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int addr, input logic [3:0] c, input logic d = 1'b0);
        w_addr   = 19'(addr);
        color_in = c;
        en_w     = 1'b1;
        done     = d;
        @(negedge clk);
        en_w = 1'b0;
        done = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic frame_end();
        row = 9'd479;
        col = 10'd639;
        @(negedge clk);
        row = 9'd500;
        col = '0;
    endtask

    task automatic scan(input int r, input int c, input logic [11:0] exp);
        exp_t e;
        e.rgb = exp;
        e.r   = r;
        e.c   = c;
        exp_q.push_back(e);
        row     = 9'(r);
        col     = 10'(c);
        tag_now = 1'b1;
        @(negedge clk);
        tag_now = 1'b0;
        row     = 9'd500;
        col     = '0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < FB_DEPTH + 16) begin
            @(negedge clk);
            n++;
        end
        check(name, n, FB_DEPTH);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("ready_in_reset", {31'd0, ready}, 0);
        check("rgb_in_reset", {20'd0, rgb_now}, 0);
        rst = 1'b0;
`ifdef FB_DBUF_CLEAR_EN
        wait_ready("clear_cycles_after_reset");
        pulse_done();
        frame_end();
        check("ready_low_after_swap", {31'd0, ready}, 0);
        wait_ready("clear_cycles_after_swap");
        scan(0, 0, 12'h000);
        scan(1, 1, 12'h000);
        scan(479, 639, 12'h000);
        idle(4);
`else
        @(negedge clk);
        check("ready_after_reset", {31'd0, ready}, 1);
        check("rgb_after_reset", {20'd0, rgb_now}, 0);

        // First frame into buffer 1, then swap it to the front.
        wr(0, 4'b0001);
        wr(641, 4'b0100);
        wr(5, 4'b0010);
        pulse_done();
        check("ready_low_wait1", {31'd0, ready}, 0);
        frame_end();
        check("ready_after_swap1", {31'd0, ready}, 1);
        scan(0, 0, 12'hF00);
        scan(1, 1, 12'h00F);
        scan(0, 5, 12'h0F0);
        idle(4);

        // Second frame into buffer 0; front must not change before the boundary.
        wr(641, 4'b1110);
        wr(5, 4'b1001);
        wr(0, 4'b1111);
        scan(1, 1, 12'h00F);
        row = 9'd100;
        col = 10'd20;
        pulse_done();
        check("ready_low_at_done", {31'd0, ready}, 0);
        wr(5, 4'b0111);
        scan(0, 0, 12'hF00);
        row = 9'd479;
        col = 10'd638;
        @(negedge clk);
        row = 9'd478;
        col = 10'd639;
        @(negedge clk);
        check("no_early_swap", {31'd0, ready}, 0);
        frame_end();
        check("ready_after_swap2", {31'd0, ready}, 1);
        scan(1, 1, 12'h088);
        scan(0, 5, 12'h800);
        scan(0, 0, 12'h888);
        idle(4);

        // Out-of-range write, last address written together with done, blanking.
        wr(307200, 4'b1111);
        wr(307199, 4'b0001, 1'b1);
        check("ready_low_wr_done", {31'd0, ready}, 0);
        frame_end();
        check("ready_after_swap3", {31'd0, ready}, 1);
        scan(479, 639, 12'hF00);
        scan(0, 0, 12'hF00);
        scan(1, 1, 12'h00F);
        scan(0, 641, 12'h000);
        scan(0, 700, 12'h000);
        scan(490, 0, 12'h000);
        idle(4);

        // Reset during WAIT_SWAP: front returns to buffer 0, no swap happens.
        wr(10, 4'b0011);
        pulse_done();
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        check("ready_mid_reset", {31'd0, ready}, 0);
        check("rgb_mid_reset", {20'd0, rgb_now}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", {31'd0, ready}, 1);
        scan(1, 1, 12'h088);
        scan(0, 10, 12'hFF0);
        frame_end();
        scan(0, 10, 12'hFF0);
        idle(4);
`endif
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
